// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
package alu_arb_pkg;

  // Request opcodes; encodings above OP_SUB are illegal.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_SUB  = 3'b100
  } op_e;

  // Arbiter control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Function select codes of the four-function ALU.
  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  // SUB is built as ~B, then A + ~B, then +1.
  localparam logic [1:0] SUB_PASSES = 2'd3;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 16-bit four-function ALU: ADD, AND, NOT(A), PASS(A).
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [1:0]  aluk_i,
  output logic [15:0] out_o
);

  // Select the ALU function; arithmetic wraps modulo 2^16.
  always_comb begin
    out_o = 16'h0000;
    case (aluk_i)
      ALUK_ADD:  out_o = a_i + b_i;
      ALUK_AND:  out_o = a_i & b_i;
      ALUK_NOT:  out_o = ~a_i;
      ALUK_PASS: out_o = a_i;
      default:   out_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one four-function ALU.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [2:0]  req_op0_i,
  input  logic [2:0]  req_op1_i,
  input  logic [15:0] req_a0_i,
  input  logic [15:0] req_b0_i,
  input  logic [15:0] req_a1_i,
  input  logic [15:0] req_b1_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [15:0] resp_data_o,
  output logic        resp_id_o,
  output logic        resp_err_o
);

  state_e      state_q;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic        id_q;
  logic        last_q;
  logic [1:0]  pass_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [1:0]  aluk_q;
  logic        resp_valid_q;
  logic [15:0] resp_data_q;
  logic        resp_id_q;
  logic        resp_err_q;

  logic [1:0]  grant_vec;
  logic        grant_id;
  logic [2:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [15:0] alu_out;

  alu_arbiter_alu u_alu (
    .a_i    (alu_a_q),
    .b_i    (alu_b_q),
    .aluk_i (aluk_q),
    .out_o  (alu_out)
  );

  // Round-robin grant in IDLE: on contention favour the requester not served last.
  always_comb begin
    grant_vec = 2'b00;
    grant_id  = 1'b0;
    if (state_q == ST_IDLE) begin
      case (req_valid_i)
        2'b01: begin grant_vec = 2'b01; grant_id = 1'b0; end
        2'b10: begin grant_vec = 2'b10; grant_id = 1'b1; end
        2'b11: begin
          if (last_q) begin
            grant_vec = 2'b01;
            grant_id  = 1'b0;
          end else begin
            grant_vec = 2'b10;
            grant_id  = 1'b1;
          end
        end
        default: begin grant_vec = 2'b00; grant_id = 1'b0; end
      endcase
    end else begin
      grant_vec = 2'b00;
      grant_id  = 1'b0;
    end
  end

  // Route the granted requester's opcode and operands.
  always_comb begin
    if (grant_id) begin
      sel_op = req_op1_i;
      sel_a  = req_a1_i;
      sel_b  = req_b1_i;
    end else begin
      sel_op = req_op0_i;
      sel_a  = req_a0_i;
      sel_b  = req_b0_i;
    end
  end

  // Control FSM: accept, sequence the ALU passes, hold the response until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'b000;
      a_q          <= 16'h0000;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      pass_q       <= 2'd0;
      alu_a_q      <= 16'h0000;
      alu_b_q      <= 16'h0000;
      aluk_q       <= ALUK_ADD;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vec != 2'b00) begin
            state_q <= ST_EXEC;
            op_q    <= sel_op;
            a_q     <= sel_a;
            id_q    <= grant_id;
            last_q  <= grant_id;
            pass_q  <= 2'd0;
            case (sel_op)
              OP_ADD:  begin aluk_q <= ALUK_ADD;  alu_a_q <= sel_a; alu_b_q <= sel_b; end
              OP_AND:  begin aluk_q <= ALUK_AND;  alu_a_q <= sel_a; alu_b_q <= sel_b; end
              OP_NOT:  begin aluk_q <= ALUK_NOT;  alu_a_q <= sel_a; alu_b_q <= sel_b; end
              OP_PASS: begin aluk_q <= ALUK_PASS; alu_a_q <= sel_a; alu_b_q <= sel_b; end
              // First SUB pass inverts B, so B is steered onto the A port.
              OP_SUB:  begin aluk_q <= ALUK_NOT;  alu_a_q <= sel_b; alu_b_q <= sel_b; end
              default: begin aluk_q <= ALUK_PASS; alu_a_q <= 16'h0000; alu_b_q <= 16'h0000; end
            endcase
          end
        end
        ST_EXEC: begin
          if ((op_q == OP_SUB) && (pass_q != (SUB_PASSES - 2'd1))) begin
            // The ALU output acts as the accumulator between SUB passes.
            pass_q <= pass_q + 2'd1;
            aluk_q <= ALUK_ADD;
            if (pass_q == 2'd0) begin
              alu_a_q <= a_q;
              alu_b_q <= alu_out;
            end else begin
              alu_a_q <= alu_out;
              alu_b_q <= 16'h0001;
            end
          end else begin
            state_q      <= ST_DONE;
            pass_q       <= 2'd0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_err_q   <= ~op_is_legal(op_q);
            resp_data_q  <= op_is_legal(op_q) ? alu_out : 16'h0000;
          end
        end
        ST_DONE: begin
          if (resp_ready_i) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = grant_vec;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences, random scoreboard.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    bit          exp_e;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    bit          e;
    bit          id;
    int          due;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  alu_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op0_i    (op0),
    .req_op1_i    (op1),
    .req_a0_i     (a0),
    .req_b0_i     (b0),
    .req_a1_i     (a1),
    .req_b1_i     (b1),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .resp_err_o   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference semantics straight from the opcode table.
  function automatic logic [15:0] ref_data(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return ~a;
      3'd3:    return a;
      3'd4:    return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic idle_inputs();
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    op0 = 3'd0; op1 = 3'd0;
    a0 = 16'h0000; b0 = 16'h0000; a1 = 16'h0000; b1 = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_req(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      op1 = op; a1 = a; b1 = b; req_valid = 2'b10;
    end else begin
      op0 = op; a0 = a; b0 = b; req_valid = 2'b01;
    end
  endtask

  // One isolated transaction with latency, result and ALU-code sequence checks.
  task automatic run_one(input string name, input vec_t v);
    int edges;
    logic [1:0] aluk_seen [3];
    aluk_seen[0] = 2'b11; aluk_seen[1] = 2'b11; aluk_seen[2] = 2'b11;
    @(negedge clk);
    drive_req(v.id, v.op, v.a, v.b);
    resp_ready = 1'b1;
    #1;
    check({name, " ready"}, 32'(req_ready), v.id ? 32'h2 : 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    edges = 0;
    while (!resp_valid && edges < 12) begin
      if (edges < 3) aluk_seen[edges] = dut.u_alu.aluk_i;
      #1;
      check({name, " busy ready"}, 32'(req_ready), 32'h0);
      @(negedge clk);
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'(v.lat));
    check({name, " data"}, 32'(resp_data), 32'(v.exp_d));
    check({name, " err"}, 32'(resp_err), 32'(v.exp_e));
    check({name, " id"}, 32'(resp_id), 32'(v.id));
    if (v.op == 3'b100)
      check({name, " aluk seq"}, 32'({aluk_seen[0], aluk_seen[1], aluk_seen[2]}), 32'h20);
    @(negedge clk);
    check({name, " valid fall"}, 32'(resp_valid), 32'h0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int grants [4];
    int gcyc [4];
    logic [15:0] rdata [4];
    int ng, nr, cyc;
    bit m_last;
    logic [1:0] exp_rdy;
    exp_t e;

    rst = 1'b1;
    idle_inputs();
    vecs[0] = '{1'b0, 3'b000, 16'h1234, 16'h0FF0, 16'h2224, 1'b0, 1};
    vecs[1] = '{1'b1, 3'b100, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 3};
    vecs[2] = '{1'b0, 3'b001, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1};
    vecs[3] = '{1'b1, 3'b010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1};
    vecs[4] = '{1'b0, 3'b011, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b0, 1};
    vecs[5] = '{1'b1, 3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1};
    vecs[6] = '{1'b0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1};
    vecs[7] = '{1'b1, 3'b100, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 3};
    vecs[8] = '{1'b0, 3'b101, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1};
    vecs[9] = '{1'b0, 3'b100, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 3};

    // Reset state.
    do_reset();
    @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_data", 32'(resp_data), 32'h0);
    check("reset resp_id", 32'(resp_id), 32'h0);
    check("reset resp_err", 32'(resp_err), 32'h0);
    #1;
    check("reset ready idle", 32'(req_ready), 32'h0);

    // Continuous dual PASS requests: grants alternate from requester 0.
    op0 = 3'b011; a0 = 16'hAAAA; b0 = 16'h0000;
    op1 = 3'b011; a1 = 16'h5555; b1 = 16'h0000;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin
        grants[ng] = (req_ready == 2'b10) ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      if (resp_valid) begin
        rdata[nr] = resp_data;
        nr++;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    check("rr response count", 32'(nr), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr grant%0d", i), 32'(grants[i]), 32'(i % 2));
      check($sformatf("rr data%0d", i), 32'(rdata[i]), (i % 2 == 0) ? 32'hAAAA : 32'h5555);
    end
    check("rr issue interval", 32'(gcyc[1] - gcyc[0]), 32'h3);

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) run_one($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: response held for 5 cycles with both requesters knocking.
    @(negedge clk);
    drive_req(1'b0, 3'b001, 16'hF0F0, 16'h3C3C);
    resp_ready = 1'b0;
    @(negedge clk);
    op0 = 3'b011; op1 = 3'b011; req_valid = 2'b11;
    cyc = 0;
    while (!resp_valid && cyc < 10) begin @(negedge clk); cyc++; end
    check("hold first valid", 32'(resp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold data c%0d", i), 32'(resp_data), 32'h3030);
      check($sformatf("hold valid c%0d", i), 32'(resp_valid), 32'h1);
      check($sformatf("hold ready c%0d", i), 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold single resp c%0d", i), 32'(resp_valid), 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b0;

    // Reset mid-SUB: no response, pointer back to requester 0.
    do_reset();
    run_one("pre-abort add", '{1'b0, 3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1});
    @(negedge clk);
    drive_req(1'b0, 3'b100, 16'h0009, 16'h0004);
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort valid c%0d", i), 32'(resp_valid), 32'h0);
      @(negedge clk);
    end
    op0 = 3'b011; op1 = 3'b011; req_valid = 2'b11;
    #1;
    check("abort next grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Random traffic against a transaction-level scoreboard.
    do_reset();
    sb.delete();
    m_last = 1'b1;
    for (cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (cyc < 1470) begin
        req_valid  = 2'($urandom_range(0, 3));
        resp_ready = ($urandom_range(0, 9) < 7);
      end else begin
        req_valid  = 2'b00;
        resp_ready = 1'b1;
      end
      op0 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      op1 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      a0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      a1 = 16'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      #1;
      if (sb.size() != 0) exp_rdy = 2'b00;
      else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      else exp_rdy = req_valid;
      check("rand ready", 32'(req_ready), 32'(exp_rdy));
      if (sb.size() != 0 && cyc >= sb[0].due) begin
        check("rand valid", 32'(resp_valid), 32'h1);
        check("rand data", 32'(resp_data), 32'(sb[0].d));
        check("rand id", 32'(resp_id), 32'(sb[0].id));
        check("rand err", 32'(resp_err), 32'(sb[0].e));
        if (resp_ready) void'(sb.pop_front());
      end else begin
        check("rand valid idle", 32'(resp_valid), 32'h0);
      end
      if (exp_rdy != 2'b00) begin
        e.id  = (exp_rdy == 2'b10);
        e.d   = e.id ? ref_data(op1, a1, b1) : ref_data(op0, a0, b0);
        e.e   = e.id ? (op1 > 3'd4) : (op0 > 3'd4);
        e.due = cyc + 1 + ((e.id ? op1 : op0) == 3'd4 ? 3 : 1);
        sb.push_back(e);
        m_last = e.id;
      end
    end
    check("rand drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-006 req_op0, req_op1  in  3 each  opcode: 000 ADD, 001 AND, 010 NOT(A), 011 PASS(A), 100 SUB(A-B); 101-111 illegal.
REQ-007 req_a0, req_b0, req_a1, req_b1  in  16 each  operands per requester.
REQ-008 resp_valid  out  1  result available.
REQ-009 resp_ready  in  1  consumer accepts result.
REQ-010 resp_data  out  16  result word.
REQ-011 resp_id  out  1  index of the requester that owns the result.
REQ-012 resp_err  out  1  set when the accepted opcode was illegal.

Function
REQ-013 States SHALL be IDLE, EXEC, DONE.
REQ-014 IDLE: req_ready SHALL be combinational, granting exactly one valid requester; the transfer is req_valid[i] & req_ready[i].
REQ-015 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-016 The last-grant pointer SHALL update only on an accepted transfer.
REQ-017 On acceptance, op, A, B and the id SHALL be registered; the state moves to EXEC.
REQ-018 req_ready SHALL be 2'b00 in EXEC and DONE; inputs are ignored while busy.
REQ-019 ADD, AND, NOT and PASS SHALL take one EXEC cycle, using ALU code 00, 01, 10 and 11 respectively.
REQ-020 SUB SHALL take three EXEC cycles: pass 1 acc = ~B (code 10); pass 2 acc = A + acc (code 00); pass 3 acc = acc + 16'h0001 (code 00).
REQ-021 Illegal opcodes SHALL take one EXEC cycle and return resp_data 16'h0000 with resp_err=1.
REQ-022 Arithmetic SHALL be 16-bit modulo 2^16 with no carry or overflow output (for example, 16'hFFFF + 16'h0001 = 16'h0000).
REQ-023 Latency: accept on edge t; resp_valid SHALL rise after edge t+1 for single-pass ops, and after edge t+3 for SUB.
REQ-024 DONE: resp_valid, resp_data, resp_id and resp_err SHALL hold stable until resp_valid & resp_ready.
REQ-025 After that handshake edge the state SHALL return to IDLE, and resp_valid SHALL fall the same edge.
REQ-026 A new request SHALL NOT be accepted in the same cycle as a response handshake; minimum issue interval is 3 cycles for single-pass ops.
REQ-027 resp_ready asserted outside DONE SHALL have no effect.
REQ-028 A requester dropping req_valid while not granted SHALL lose no state; there is no starvation under continuous dual requests.

Reset
REQ-029 Reset SHALL force: state IDLE; resp_valid 0; resp_data 16'h0000; resp_id 0; resp_err 0; pass counter 0; last-grant pointer = 1, so requester 0 wins first.
REQ-030 Reset asserted mid-EXEC or mid-DONE SHALL abort the operation with no response emitted.

Structure
REQ-031 The opcode enum, state enum, ALU code constants (ADD 00, AND 01, NOT 10, PASS 11) and the SUB pass count SHALL live in a shared package, alu_arb_pkg.
REQ-032 The block SHALL instantiate exactly one ALU sub-module: the team's existing 16-bit four-function ALU (A, B, ALUK, Out), driven by a registered operand mux and code mux.
REQ-033 The pass counter SHALL be 2 bits wide.

Verification
REQ-034 Requester 0 ADD A=16'h1234, B=16'h0FF0, resp_ready=1 -> resp_data 16'h2224, resp_id 0, resp_err 0, resp_valid rises 1 cycle after acceptance.
REQ-035 Requester 1 SUB A=16'h0005, B=16'h0007 -> resp_data 16'hFFFE after 3 EXEC cycles; ALUK sequence 10, 00, 00.
REQ-036 Both requesters valid continuously with PASS A0=16'hAAAA, A1=16'h5555 -> grants alternate 0, 1, 0, 1 from reset; responses alternate 16'hAAAA and 16'h5555.
REQ-037 resp_ready held 0 for 5 cycles after AND 16'hF0F0 & 16'h3C3C -> resp_data stays 16'h3030; req_ready stays 00; a single response on release.
REQ-038 Opcode 3'b111 -> resp_data 16'h0000, resp_err 1; then ADD 16'hFFFF + 16'h0001 -> 16'h0000, resp_err 0.
REQ-039 Reset pulsed during SUB pass 2 -> resp_valid stays 0, state returns to IDLE, and the next grant goes to requester 0.
